// File: rtl/systolic_drain_ctrl.sv
// Drains a SIZE x SIZE systolic array row by row and streams the results in row-major order over a valid/ready port.
// Define SYSTOLIC_DRAIN_RELU_EN to clamp negative results to zero on out_msg.
module systolic_drain_ctrl #(
    parameter int unsigned SIZE = 16,
    parameter int unsigned DW   = 32,
    localparam int unsigned RW  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mac_done,
    output logic [RW-1:0]      row_sel,
    input  logic [SIZE*DW-1:0] row_data,
    output logic [DW-1:0]      out_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic               acc_clr,
    output logic               busy,
    output logic               done
);

    localparam logic [RW-1:0] LAST = RW'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        CLEAR = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [RW-1:0]       r_q, r_d;
    logic [RW-1:0]       c_q, c_d;
    logic [SIZE*DW-1:0]  row_buf_q, row_buf_d;
    logic [DW-1:0]       col_sel;

    // State, counters and the buffered row
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            c_q       <= '0;
            row_buf_q <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            row_buf_q <= row_buf_d;
        end
    end

    // Next-state and state-decoded control outputs
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        row_buf_d = row_buf_q;
        busy      = 1'b1;
        out_val   = 1'b0;
        acc_clr   = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                r_d  = '0;
                c_d  = '0;
                if (mac_done) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                row_buf_d = row_data;
                c_d       = '0;
                state_d   = SEND;
            end
            SEND: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    if (c_q != LAST) begin
                        c_d = c_q + RW'(1);
                    end else if (r_q != LAST) begin
                        r_d     = r_q + RW'(1);
                        state_d = FETCH;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                acc_clr = 1'b1;
                done    = 1'b1;
                r_d     = '0;
                c_d     = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Column select out of the buffered row
    always_comb begin
        col_sel = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (c_q == RW'(i)) begin
                col_sel = row_buf_q[i*DW +: DW];
            end
        end
    end

`ifdef SYSTOLIC_DRAIN_RELU_EN
    assign out_msg = col_sel[DW-1] ? '0 : col_sel;
`else
    assign out_msg = col_sel;
`endif

    assign row_sel = r_q;

endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// Randomized scoreboard bench for systolic_drain_ctrl (3x3 array) plus directed runs on a 1x1 instance.
module tb_systolic_drain_ctrl;

    localparam int unsigned SIZE = 3;
    localparam int unsigned DW   = 8;
    localparam int unsigned RW   = 2;
    localparam int unsigned NV   = SIZE * SIZE;

    logic               clk = 1'b0;
    logic               rst;
    logic               mac_done;
    logic               out_rdy;
    logic [RW-1:0]      row_sel;
    logic [SIZE*DW-1:0] row_data;
    logic [DW-1:0]      out_msg;
    logic               out_val;
    logic               acc_clr;
    logic               busy;
    logic               done;

    logic               s_mac;
    logic [DW-1:0]      s_data;
    logic [0:0]         s_row_sel;
    logic [DW-1:0]      s_msg;
    logic               s_val;
    logic               s_clr;
    logic               s_busy;
    logic               s_done;

    logic [DW-1:0]      mem [SIZE][SIZE];

    int                 n_checks = 0;
    int                 n_errors = 0;

    bit                 mon_en = 1'b0;
    bit                 m_active = 1'b0;
    bit                 m_clear_now = 1'b0;
    bit                 m_need_fetch = 1'b0;
    int                 m_xfers = 0;
    logic [DW-1:0]      exp_q [$];
    bit                 hold_pend = 1'b0;
    logic [DW-1:0]      hold_msg;

    always #5 clk = ~clk;

    systolic_drain_ctrl #(.SIZE(SIZE), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .mac_done (mac_done),
        .row_sel  (row_sel),
        .row_data (row_data),
        .out_msg  (out_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .acc_clr  (acc_clr),
        .busy     (busy),
        .done     (done)
    );

    systolic_drain_ctrl #(.SIZE(1), .DW(DW)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .mac_done (s_mac),
        .row_sel  (s_row_sel),
        .row_data (s_data),
        .out_msg  (s_msg),
        .out_val  (s_val),
        .out_rdy  (1'b1),
        .acc_clr  (s_clr),
        .busy     (s_busy),
        .done     (s_done)
    );

    // The array model: the selected row of mem is presented combinationally
    always_comb begin
        row_data = '0;
        for (int r = 0; r < SIZE; r++) begin
            if (row_sel == RW'(r)) begin
                for (int c = 0; c < SIZE; c++) begin
                    row_data[c*DW +: DW] = mem[r][c];
                end
            end
        end
    end

    function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] v);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor + reference model, evaluated mid-cycle when everything is stable
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_val;
            bit xfer_m;
            exp_val = m_active && !m_need_fetch && !m_clear_now;
            xfer_m  = exp_val && out_rdy;
            chk("busy", 32'(busy), 32'(m_active));
            chk("out_val", 32'(out_val), 32'(exp_val));
            chk("done", 32'(done), 32'(m_clear_now));
            chk("acc_clr", 32'(acc_clr), 32'(m_clear_now));
            if (!m_clear_now) begin
                chk("row_sel", 32'(row_sel), m_active ? 32'(m_xfers / SIZE) : 32'd0);
            end else begin
                chk("all_sent_at_done", 32'(exp_q.size()), 32'd0);
            end
            if (hold_pend) begin
                chk("hold_val", 32'(out_val), 32'd1);
                chk("hold_msg", 32'(out_msg), 32'(hold_msg));
            end
            hold_pend = 1'b0;
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL data at %0t: got %0h expected nothing", $time, out_msg);
                end else begin
                    chk("data", 32'(out_msg), 32'(exp_q.pop_front()));
                end
            end else if (out_val) begin
                hold_pend = 1'b1;
                hold_msg  = out_msg;
            end
            // Advance the model to what the coming edge should produce
            if (rst) begin
                m_active     = 1'b0;
                m_clear_now  = 1'b0;
                m_need_fetch = 1'b0;
                hold_pend    = 1'b0;
                exp_q.delete();
            end else if (m_clear_now) begin
                m_active    = 1'b0;
                m_clear_now = 1'b0;
            end else if (m_active) begin
                if (m_need_fetch) begin
                    m_need_fetch = 1'b0;
                end else if (xfer_m) begin
                    m_xfers++;
                    if (m_xfers == NV) m_clear_now = 1'b1;
                    else if (m_xfers % SIZE == 0) m_need_fetch = 1'b1;
                end
            end else if (mac_done) begin
                m_active     = 1'b1;
                m_need_fetch = 1'b1;
                m_xfers      = 0;
                for (int r = 0; r < SIZE; r++)
                    for (int c = 0; c < SIZE; c++)
                        exp_q.push_back(ref_out(mem[r][c]));
            end
        end
    end

    task automatic run_drain(input int pct, input bit trig, input bit rmid);
        bit did_rst = 1'b0;
        int cyc = 0;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                mem[r][c] = DW'($urandom);
        @(posedge clk); #1;
        mac_done = 1'b1;
        out_rdy  = ($urandom_range(0, 99) < 32'(pct));
        forever begin
            @(posedge clk); #1;
            rst      = 1'b0;
            mac_done = 1'b0;
            if (!m_active) break;
            cyc++;
            if (cyc > 2000) begin
                n_checks++;
                n_errors++;
                $display("FAIL drain_timeout: got %0d cycles expected at most 2000", cyc);
                break;
            end
            out_rdy = ($urandom_range(0, 99) < 32'(pct));
            if (trig && $urandom_range(0, 3) == 0) mac_done = 1'b1;
            if (rmid && !did_rst && m_xfers == 2) begin
                rst     = 1'b1;
                did_rst = 1'b1;
            end
        end
    endtask

    task automatic one_drain(input logic [DW-1:0] v);
        s_data = v;
        @(posedge clk); #1 s_mac = 1'b1;
        @(posedge clk); #1 s_mac = 1'b0;
        @(negedge clk);
        chk("s1_fetch_busy", 32'(s_busy), 32'd1);
        chk("s1_fetch_val", 32'(s_val), 32'd0);
        @(negedge clk);
        chk("s1_send_val", 32'(s_val), 32'd1);
        chk("s1_send_msg", 32'(s_msg), 32'(ref_out(v)));
        chk("s1_send_done", 32'(s_done), 32'd0);
        @(negedge clk);
        chk("s1_clear_done", 32'(s_done), 32'd1);
        chk("s1_clear_clr", 32'(s_clr), 32'd1);
        chk("s1_clear_val", 32'(s_val), 32'd0);
        @(negedge clk);
        chk("s1_idle_busy", 32'(s_busy), 32'd0);
        chk("s1_idle_done", 32'(s_done), 32'd0);
        chk("s1_row_sel", 32'(s_row_sel), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        mac_done = 1'b0;
        out_rdy  = 1'b0;
        s_mac    = 1'b0;
        s_data   = '0;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                mem[r][c] = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        chk("rst_out_msg", 32'(out_msg), 32'd0);
        chk("rst_row_sel", 32'(row_sel), 32'd0);
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_drain(100, 1'b0, 1'b0);
        run_drain(100, 1'b1, 1'b0);
        run_drain(50,  1'b0, 1'b0);
        run_drain(60,  1'b1, 1'b1);
        run_drain(100, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_drain(int'($urandom_range(20, 100)), 1'b1, ($urandom_range(0, 3) == 0));
        end

        // Reset wins over a simultaneous trigger
        @(posedge clk); #1;
        rst      = 1'b1;
        mac_done = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        mac_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        one_drain(8'h07);
        one_drain(8'hF0);
        one_drain(8'h05);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
